alu_resp_checker: RTL

Response-side self-check block for the 8-bit ALU: it receives each issued operation (operands, `alu_op`) with the ALU's observed `Result` and flags, recomputes the expected response with a golden model, and counts pass/fail/skip over a programmed run. It sits downstream of `alu` and `alu_control`, alongside the stimulus path, and lets silicon or FPGA builds self-test without a simulator bench. It reports a pass verdict, saturating counters, and a capture of the first mismatch.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_ref_model.sv | 53 +++++
 rtl/alu_resp_checker.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode, flag-position, checker FSM and MISR definitions shared by
// the ALU response checker and its golden model.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;

  // Flag vector is {C, Z, V, N} from bit 3 down to bit 0.
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chk_state_t;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/alu_ref_model.sv
// alu_ref_model: combinational golden model of the ALU; known_op is low for
// opcodes the checker does not verify.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             known_op
);

  logic [WIDTH:0] sum;
  logic           carry;
  logic           ovf;

  always_comb begin
    sum      = '0;
    result   = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    known_op = 1'b1;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Carry out of A + ~B + 1 is the inverted borrow.
        sum    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      default: known_op = 1'b0;
    endcase
    flags         = '0;
    flags[FLAG_C] = carry;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_V] = ovf;
    flags[FLAG_N] = result[WIDTH-1];
  end

endmodule

// File: rtl/alu_resp_checker.sv
// alu_resp_checker: two-stage self-check of observed ALU responses against a
// golden model. Build with ALU_CHK_MISR_EN to add the 16-bit MISR signature.
module alu_resp_checker
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   n_samples,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [3:0]         in_op,
  input  logic [WIDTH-1:0]   in_result,
  input  logic [3:0]         in_flags,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               mismatch,
  output logic [CNT_W-1:0]   pass_count,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   skip_count,
  output logic [CNT_W-1:0]   fail_index,
  output logic [3:0]         fail_op,
  output logic [WIDTH+3:0]   fail_expected,
  output logic [WIDTH+3:0]   fail_observed,
  output logic [15:0]        signature
);

  localparam int RW = WIDTH + 4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  chk_state_t       state;
  logic [CNT_W-1:0] n_reg;
  logic [CNT_W-1:0] acc_cnt;
  logic             accept;

  logic             vld_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [3:0]       op_p1;
  logic [WIDTH-1:0] res_p1;
  logic [3:0]       flg_p1;
  logic [CNT_W-1:0] idx_p1;

  logic [WIDTH-1:0] exp_res;
  logic [3:0]       exp_flg;
  logic             known;
  logic [RW-1:0]    exp_p1;
  logic [RW-1:0]    obs_p1;
  logic             bad_p1;
  logic             last_p1;

  // A sample coinciding with start belongs to no run and is dropped.
  assign accept = (state == ST_RUN) && in_valid && !start && (acc_cnt < n_reg);

  // ---- stage 1: capture accepted sample and its index ----
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1   <= in_a;
      b_p1   <= in_b;
      op_p1  <= in_op;
      res_p1 <= in_result;
      flg_p1 <= in_flags;
      idx_p1 <= acc_cnt;
    end
  end

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a        (a_p1),
    .b        (b_p1),
    .op       (op_p1),
    .result   (exp_res),
    .flags    (exp_flg),
    .known_op (known)
  );

  assign exp_p1  = {exp_flg, exp_res};
  assign obs_p1  = {flg_p1, res_p1};
  assign bad_p1  = known && (obs_p1 != exp_p1);
  assign last_p1 = vld_p1 && (idx_p1 == n_reg - CNT_W'(1));

  // ---- stage 2: counters, mismatch pulse, first-fail capture, FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      n_reg         <= '0;
      acc_cnt       <= '0;
      vld_p1        <= 1'b0;
      mismatch      <= 1'b0;
      pass_count    <= '0;
      err_count     <= '0;
      skip_count    <= '0;
      fail_index    <= '0;
      fail_op       <= '0;
      fail_expected <= '0;
      fail_observed <= '0;
    end else if (start) begin
      state         <= (n_samples == '0) ? ST_DONE : ST_RUN;
      n_reg         <= n_samples;
      acc_cnt       <= '0;
      vld_p1        <= 1'b0;
      mismatch      <= 1'b0;
      pass_count    <= '0;
      err_count     <= '0;
      skip_count    <= '0;
      fail_index    <= '0;
      fail_op       <= '0;
      fail_expected <= '0;
      fail_observed <= '0;
    end else begin
      vld_p1   <= accept;
      mismatch <= vld_p1 && bad_p1;
      if (accept)
        acc_cnt <= acc_cnt + CNT_W'(1);
      if (vld_p1) begin
        if (!known) begin
          skip_count <= sat_inc(skip_count);
        end else if (bad_p1) begin
          err_count <= sat_inc(err_count);
          if (err_count == '0) begin
            fail_index    <= idx_p1;
            fail_op       <= op_p1;
            fail_expected <= exp_p1;
            fail_observed <= obs_p1;
          end
        end else begin
          pass_count <= sat_inc(pass_count);
        end
      end
      if ((state == ST_RUN) && last_p1)
        state <= ST_DONE;
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == '0);

`ifdef ALU_CHK_MISR_EN
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [RW-1:0] obs);
    logic [15:0] t;
    t = s ^ 16'(obs);
    return {t[14:0], 1'b0} ^ (t[15] ? MISR_POLY : 16'h0000);
  endfunction

  logic [15:0] misr;

  // Retirements only happen in RUN, so the signature holds once DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      misr <= '0;
    else if (start)
      misr <= MISR_SEED;
    else if (vld_p1)
      misr <= misr_step(misr, obs_p1);
  end

  assign signature = misr;
`else
  assign signature = 16'h0000;
`endif

endmodule
